rr_req_queue: RTL and testbench
===============================

# rr_req_queue

Request front end for the 4-way round-robin arbiter. Buffers commands from four independent sources in per-channel FIFOs, drives the arbiter's `req3..req0` lines from FIFO occupancy, consumes the arbiter's `gnt3..gnt0` grants, and forwards each granted command onto a single shared output port tagged with its source channel. It sits directly upstream of the arbiter and produces its requests; it is also the consumer of its grants.

## Interface
- `DATA_W`, 8: command payload width.
- `DEPTH`, 4: entries per channel FIFO; power of two, ≥2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  4  bit N pushes `wr_dataN` into FIFO N.
- `wr_data0`..`wr_data3`  in  DATA_W each  command payload per channel.
- `full`  out  4  bit N high when FIFO N holds DEPTH entries.
- `req3`, `req2`, `req1`, `req0`  out  1 each  to the arbiter; reqN = FIFO N non-empty.
- `gnt3`, `gnt2`, `gnt1`, `gnt0`  in  1 each  from the arbiter; one-hot or zero.
- `out_valid`  out  1  registered; high for one cycle per forwarded command.
- `out_data`  out  DATA_W  payload of forwarded command.
- `out_src`  out  2  channel index of forwarded command.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Per channel: circular FIFO, read pointer, write pointer (log2(DEPTH) bits, natural wrap), occupancy count (log2(DEPTH)+1 bits, 0..DEPTH).
- Push: `wr_en[N]` and count<DEPTH → store at wptr, wptr+1. Push when full is dropped silently; no state change, `err` unaffected.
- `reqN` is derived from registered count only (count≠0); no combinational path from `gntN` or `wr_en` to `reqN`.
- Pop: on an edge where exactly one `gntN` is high and `reqN` is high → head of FIFO N is captured into `out_data`, `out_src`=N, `out_valid`=1; rptr+1, count−1.
- Grant to a channel whose `reqN` is low (arbiter grant lagging a dropped request): ignored, no pop, `out_valid`=0, no error.
- More than one `gnt` high in a cycle: no pop on any channel, `out_valid`=0, `err` set and held until reset.
- No grant: `out_valid`=0; `out_data`/`out_src` hold last values.
- Simultaneous push and pop on the same channel: both take effect, count unchanged; legal when full (pop frees the slot in the same edge, push accepted) and when count=1.
- Push into an empty FIFO while `gntN` is high: push accepted, no pop that cycle (`reqN` was low).
- Grant held for consecutive cycles pops one entry per cycle until empty; FIFO order preserved per channel.
- No output back-pressure: downstream accepts every `out_valid` cycle.

## Timing
- Reset (synchronous): all counts/pointers 0, `full`=0, `req3..req0`=0, `out_valid`=0, `out_data`=0, `out_src`=0, `err`=0. Reset asserted mid-operation discards all buffered commands on that edge; pushes and grants in the reset cycle are ignored.
- Push at edge T → `reqN` high and `full` updated after edge T (visible cycle T+1).
- Grant sampled at edge T → `out_valid`/`out_data`/`out_src` valid after edge T; `reqN` falls after edge T if that pop emptied the FIFO.
- Latency write-to-output minimum: push at T, arbiter grant seen at T+1 (if the arbiter grants combinationally) or later, output after that edge.
- Throughput: one forwarded command per cycle aggregate.

## Test plan
- Reset, then push 0xA1 to ch0 only; drive `gnt0`=1 next cycle → `req0`=1 after push, one cycle `out_valid`=1, `out_data`=0xA1, `out_src`=0, then `req0`=0.
- Push 4 entries 0x10..0x13 to ch2 with DEPTH=4, then a 5th (0x14) → `full[2]`=1, 5th dropped; grant ch2 for 4 cycles → outputs 0x10,0x11,0x12,0x13 in order, `full[2]`=0, `req2`=0.
- Full ch1, same-cycle push 0x55 and `gnt1` → pop of head, push accepted, count stays 4, `full[1]` stays 1; later drain ends with 0x55.
- All four channels loaded with one entry each; drive grants 0,1,2,3 in successive cycles → `out_src` 0,1,2,3 with matching data, all req low at end.
- `gnt1`=1 while `req1`=0 → no output, `err`=0; then `gnt0`=`gnt3`=1 together with both reqs high → no pop, `err`=1 sticky until `rst`.
- Reset asserted with entries in all FIFOs → next cycle all `req`=0, `full`=0, `out_valid`=0; subsequent grants produce no output.

Source files
------------

// File: rtl/rr_req_queue.sv
// Per-channel command FIFOs feeding the 4-way round-robin arbiter: occupancy drives
// the requests, and each single valid grant forwards one head entry to a shared port.
module rr_req_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        wr_en,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic [DATA_W-1:0] wr_data2,
    input  logic [DATA_W-1:0] wr_data3,
    output logic [3:0]        full,
    output logic              req3,
    output logic              req2,
    output logic              req1,
    output logic              req0,
    input  logic              gnt3,
    input  logic              gnt2,
    input  logic              gnt1,
    input  logic              gnt0,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    output logic              err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [4][DEPTH];
    logic [AW-1:0]     rptr [4];
    logic [AW-1:0]     wptr [4];
    logic [CW-1:0]     count [4];
    logic [DATA_W-1:0] wr_arr [4];

    logic [3:0]        gnt_vec;
    logic [3:0]        req_vec;
    logic [3:0]        pop;
    logic [3:0]        push;
    logic              multi_gnt;
    logic              any_pop;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_src;

    assign wr_arr[0] = wr_data0;
    assign wr_arr[1] = wr_data1;
    assign wr_arr[2] = wr_data2;
    assign wr_arr[3] = wr_data3;

    assign gnt_vec   = {gnt3, gnt2, gnt1, gnt0};
    assign multi_gnt = (gnt_vec & (gnt_vec - 4'd1)) != 4'd0;
    assign any_pop   = |pop;

    assign req0 = req_vec[0];
    assign req1 = req_vec[1];
    assign req2 = req_vec[2];
    assign req3 = req_vec[3];

    // A full FIFO still accepts a push when the same edge pops its head.
    always_comb begin
        req_vec = '0;
        full    = '0;
        pop     = '0;
        push    = '0;
        for (int n = 0; n < 4; n++) begin
            req_vec[n] = count[n] != '0;
            full[n]    = count[n] == FULL_CNT;
            pop[n]     = gnt_vec[n] && req_vec[n] && !multi_gnt;
            push[n]    = wr_en[n] && (!full[n] || pop[n]);
        end
    end

    always_comb begin
        sel_data = '0;
        sel_src  = '0;
        for (int n = 0; n < 4; n++) begin
            if (pop[n]) begin
                sel_data = mem[n][rptr[n]];
                sel_src  = 2'(n);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (!rst && push[n]) begin
                mem[n][wptr[n]] <= wr_arr[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                rptr[n]  <= '0;
                wptr[n]  <= '0;
                count[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (push[n]) begin
                    wptr[n] <= wptr[n] + AW'(1);
                end
                if (pop[n]) begin
                    rptr[n] <= rptr[n] + AW'(1);
                end
                case ({push[n], pop[n]})
                    2'b10:   count[n] <= count[n] + CW'(1);
                    2'b01:   count[n] <= count[n] - CW'(1);
                    default: count[n] <= count[n];
                endcase
            end
        end
    end

    // Output payload and source hold their last values between forwarded commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            err       <= 1'b0;
        end else begin
            out_valid <= any_pop;
            if (any_pop) begin
                out_data <= sel_data;
                out_src  <= sel_src;
            end
            if (multi_gnt) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_req_queue.sv
// Directed bench for rr_req_queue: queue-based channel model checked every cycle,
// plus an expected-output scoreboard and literal spot checks.
module tb_rr_req_queue;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        wr_en = '0;
    logic [DATA_W-1:0] wr_data0 = '0;
    logic [DATA_W-1:0] wr_data1 = '0;
    logic [DATA_W-1:0] wr_data2 = '0;
    logic [DATA_W-1:0] wr_data3 = '0;
    logic [3:0]        full;
    logic              req3, req2, req1, req0;
    logic              gnt3 = 1'b0, gnt2 = 1'b0, gnt1 = 1'b0, gnt0 = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_src;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    rr_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en),
        .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_data2(wr_data2), .wr_data3(wr_data3),
        .full(full),
        .req3(req3), .req2(req2), .req1(req1), .req0(req0),
        .gnt3(gnt3), .gnt2(gnt2), .gnt1(gnt1), .gnt0(gnt0),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .err(err)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: one queue per channel
    logic [DATA_W-1:0] mq [4][$];
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_data  = '0;
    logic [1:0]        m_src   = '0;
    logic              m_err   = 1'b0;
    logic              model_live = 1'b0;

    // scoreboard of {src, data} expected on the output port, in order
    logic [DATA_W+1:0] exp_q [$];

    always @(posedge clk) begin
        logic [3:0] g;
        logic [DATA_W-1:0] wd [4];
        int ng;
        g     = {gnt3, gnt2, gnt1, gnt0};
        wd[0] = wr_data0; wd[1] = wr_data1; wd[2] = wr_data2; wd[3] = wr_data3;
        ng    = 0;
        for (int n = 0; n < 4; n++) if (g[n]) ng++;
        if (rst) begin
            for (int n = 0; n < 4; n++) mq[n].delete();
            m_valid = 1'b0; m_data = '0; m_src = '0; m_err = 1'b0;
            model_live = 1'b1;
        end else begin
            m_valid = 1'b0;
            if (ng > 1) begin
                m_err = 1'b1;
            end else if (ng == 1) begin
                for (int n = 0; n < 4; n++) begin
                    if (g[n] && mq[n].size() > 0) begin
                        m_data  = mq[n].pop_front();
                        m_src   = 2'(n);
                        m_valid = 1'b1;
                    end
                end
            end
            for (int n = 0; n < 4; n++) begin
                if (wr_en[n] && mq[n].size() < DEPTH) mq[n].push_back(wd[n]);
            end
        end
    end

    // compare process, sampled 1 time unit after the active edge
    always @(posedge clk) begin
        logic [DATA_W+1:0] e;
        logic [3:0] rv;
        #1;
        if (model_live) begin
            rv = {req3, req2, req1, req0};
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_src", 32'(out_src), 32'(m_src));
            check("err", 32'(err), 32'(m_err));
            for (int n = 0; n < 4; n++) begin
                check("req", 32'(rv[n]), 32'(mq[n].size() != 0));
                check("full", 32'(full[n]), 32'(mq[n].size() == DEPTH));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'({out_src, out_data}), 32'h3ff);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_output", 32'({out_src, out_data}), 32'(e));
                end
            end
        end
    end

    // driver: inputs applied at the negedge, held one full cycle
    task automatic step(input logic [3:0] we, input logic [31:0] d, input logic [3:0] g);
        wr_en    = we;
        wr_data0 = d[7:0];
        wr_data1 = d[15:8];
        wr_data2 = d[23:16];
        wr_data3 = d[31:24];
        {gnt3, gnt2, gnt1, gnt0} = g;
        @(negedge clk);
    endtask

    task automatic idle();
        step(4'b0000, 32'h0, 4'b0000);
    endtask

    task automatic expect_out(input logic [1:0] src, input logic [DATA_W-1:0] data);
        exp_q.push_back({src, data});
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_req0", 32'(req0), 32'h0);
        check("reset_full", 32'(full), 32'h0);
        check("reset_out_data", 32'(out_data), 32'h0);

        // single command through ch0
        step(4'b0001, 32'h0000_00A1, 4'b0000);
        check("t1_req0_after_push", 32'(req0), 32'h1);
        expect_out(2'd0, 8'hA1);
        step(4'b0000, 32'h0, 4'b0001);
        check("t1_out_valid", 32'(out_valid), 32'h1);
        check("t1_out_data", 32'(out_data), 32'hA1);
        check("t1_req0_after_pop", 32'(req0), 32'h0);
        idle();
        check("t1_out_valid_drop", 32'(out_valid), 32'h0);

        // ch2 fill, overflow dropped, drain in order
        for (int i = 0; i < 4; i++) step(4'b0100, {8'h0, 8'(8'h10 + i), 16'h0}, 4'b0000);
        check("t2_full2", 32'(full[2]), 32'h1);
        step(4'b0100, 32'h0014_0000, 4'b0000);
        check("t2_full2_after_drop", 32'(full[2]), 32'h1);
        for (int i = 0; i < 4; i++) begin
            expect_out(2'd2, 8'(8'h10 + i));
            step(4'b0000, 32'h0, 4'b0100);
            check("t2_drain_data", 32'(out_data), 32'(8'h10 + i));
        end
        check("t2_full2_end", 32'(full[2]), 32'h0);
        check("t2_req2_end", 32'(req2), 32'h0);
        idle();

        // ch1 full, simultaneous push and pop
        for (int i = 0; i < 4; i++) step(4'b0010, {16'h0, 8'(8'h20 + i), 8'h0}, 4'b0000);
        expect_out(2'd1, 8'h20);
        step(4'b0010, 32'h0000_5500, 4'b0010);
        check("t3_full1_held", 32'(full[1]), 32'h1);
        check("t3_popped_head", 32'(out_data), 32'h20);
        expect_out(2'd1, 8'h21);
        expect_out(2'd1, 8'h22);
        expect_out(2'd1, 8'h23);
        expect_out(2'd1, 8'h55);
        for (int i = 0; i < 4; i++) step(4'b0000, 32'h0, 4'b0010);
        check("t3_last_is_55", 32'(out_data), 32'h55);
        check("t3_req1_end", 32'(req1), 32'h0);
        idle();

        // one entry per channel, grants 0..3
        step(4'b1111, 32'h3332_3130, 4'b0000);
        check("t4_all_req", 32'({req3, req2, req1, req0}), 32'hF);
        for (int n = 0; n < 4; n++) begin
            expect_out(2'(n), 8'(8'h30 + n));
            step(4'b0000, 32'h0, 4'(1 << n));
            check("t4_src", 32'(out_src), 32'(n));
        end
        check("t4_all_req_low", 32'({req3, req2, req1, req0}), 32'h0);
        idle();

        // stale grant, then illegal double grant
        step(4'b0000, 32'h0, 4'b0010);
        check("t5_stale_no_out", 32'(out_valid), 32'h0);
        check("t5_stale_no_err", 32'(err), 32'h0);
        step(4'b1001, 32'h4300_0040, 4'b0000);
        step(4'b0000, 32'h0, 4'b1001);
        check("t5_double_no_out", 32'(out_valid), 32'h0);
        check("t5_err_set", 32'(err), 32'h1);
        check("t5_reqs_kept", 32'({req3, req0}), 32'h3);
        idle();
        check("t5_err_sticky", 32'(err), 32'h1);
        expect_out(2'd0, 8'h40);
        step(4'b0000, 32'h0, 4'b0001);
        expect_out(2'd3, 8'h43);
        step(4'b0000, 32'h0, 4'b1000);
        check("t5_err_still", 32'(err), 32'h1);

        // push into empty channel with its grant high: no pop that cycle
        step(4'b0001, 32'h0000_0077, 4'b0001);
        check("t6_push_under_gnt", 32'(out_valid), 32'h0);
        check("t6_req0", 32'(req0), 32'h1);

        // reset with entries everywhere, pushes ignored in the reset cycle
        step(4'b1111, 32'h5352_5150, 4'b0000);
        step(4'b1111, 32'h6362_6160, 4'b0000);
        rst = 1'b1;
        step(4'b1111, 32'h7372_7170, 4'b0001);
        rst = 1'b0;
        check("t7_reqs_cleared", 32'({req3, req2, req1, req0}), 32'h0);
        check("t7_full_cleared", 32'(full), 32'h0);
        check("t7_out_valid", 32'(out_valid), 32'h0);
        check("t7_err_cleared", 32'(err), 32'h0);
        for (int n = 0; n < 4; n++) begin
            step(4'b0000, 32'h0, 4'(1 << n));
            check("t7_no_output", 32'(out_valid), 32'h0);
        end
        idle();
        idle();

        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
